// File: rtl/border_box_scan.sv
`default_nettype none
// ============================================================================
// Module   : border_box_scan
// Purpose  : Walks the row/column border RAMs after each projection and emits
//            one sanitised digit bounding box per (row, col) pair on a
//            valid/ready stream.
// Revision : 1.0  initial release
// ============================================================================
module border_box_scan #(
  parameter int NUM_ROW = 1,
  parameter int NUM_COL = 3,
  parameter int H_PIXEL = 1280,
  parameter int V_PIXEL = 720,
  parameter int DEPBIT  = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              project_done_flag,
  input  logic [3:0]        num_row,
  input  logic [3:0]        num_col,
  output logic [DEPBIT-1:0] row_border_addr_rd,
  input  logic [DEPBIT-1:0] row_border_data_rd,
  output logic [DEPBIT-1:0] col_border_addr_rd,
  input  logic [DEPBIT-1:0] col_border_data_rd,
  output logic              box_valid,
  input  logic              box_ready,
  output logic [10:0]       box_x0,
  output logic [10:0]       box_x1,
  output logic [10:0]       box_y0,
  output logic [10:0]       box_y1,
  output logic [7:0]        box_idx,
  output logic              box_last,
  output logic              scan_busy,
  output logic              scan_done
);

  localparam logic [3:0]  NUM_ROW_C = 4'(NUM_ROW);
  localparam logic [3:0]  NUM_COL_C = 4'(NUM_COL);
  localparam logic [10:0] X_MAX     = 11'(H_PIXEL - 1);
  localparam logic [10:0] Y_MAX     = 11'(V_PIXEL - 1);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    ROW_A = 4'd1,
    ROW_B = 4'd2,
    ROW_W = 4'd3,
    COL_A = 4'd4,
    COL_B = 4'd5,
    COL_W = 4'd6,
    EMIT  = 4'd7,
    DONE  = 4'd8
  } state_e;

  state_e            state_q, state_d;
  logic              prev_flag_q;
  logic [3:0]        nr_q, nr_d, nc_q, nc_d, r_q, r_d, c_q, c_d;
  logic [DEPBIT-1:0] row_addr_q, row_addr_d, col_addr_q, col_addr_d;
  logic [10:0]       x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
  logic              box_valid_q, box_valid_d, box_last_q, box_last_d;
  logic [7:0]        box_idx_q, box_idx_d;
  logic              busy_q, busy_d, done_q, done_d;

  logic              flag_rise;
  logic [3:0]        nr_clamp, nc_clamp;

  // Upper RAM data bits carry nothing for an 11-bit coordinate.
  logic unused_data_bits;
  assign unused_data_bits = ^{row_border_data_rd[DEPBIT-1:11], col_border_data_rd[DEPBIT-1:11]};

  // Entry k lives at 2k+1 (start edge) and 2k+2 (end edge).
  function automatic logic [DEPBIT-1:0] edge_addr(input logic [3:0] k, input logic end_edge);
    return DEPBIT'({k, 1'b0}) + (end_edge ? DEPBIT'(2) : DEPBIT'(1));
  endfunction

  // Returns {lo, hi}: wrapped start forced to 0, end clamped to lim, lo kept <= hi.
  function automatic logic [21:0] sanitize(input logic [10:0] s, input logic [10:0] e,
                                           input logic [10:0] lim);
    logic [10:0] lo, hi;
    lo = (s > e) ? 11'd0 : s;
    hi = (e > lim) ? lim : e;
    if (lo > hi) lo = hi;
    return {lo, hi};
  endfunction

  assign flag_rise = project_done_flag & ~prev_flag_q;
  assign nr_clamp  = (num_row > NUM_ROW_C) ? NUM_ROW_C : num_row;
  assign nc_clamp  = (num_col > NUM_COL_C) ? NUM_COL_C : num_col;

  always_comb begin
    state_d     = state_q;
    nr_d        = nr_q;
    nc_d        = nc_q;
    r_d         = r_q;
    c_d         = c_q;
    row_addr_d  = row_addr_q;
    col_addr_d  = col_addr_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    y0_d        = y0_q;
    y1_d        = y1_q;
    box_valid_d = box_valid_q;
    box_last_d  = box_last_q;
    box_idx_d   = box_idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (flag_rise) begin
          nr_d      = nr_clamp;
          nc_d      = nc_clamp;
          r_d       = 4'd0;
          c_d       = 4'd0;
          box_idx_d = 8'd0;
          busy_d    = 1'b1;
          if (nr_clamp == 4'd0 || nc_clamp == 4'd0) begin
            state_d = DONE;
          end else begin
            row_addr_d = edge_addr(4'd0, 1'b0);
            state_d    = ROW_A;
          end
        end
      end
      ROW_A: begin
        row_addr_d = edge_addr(r_q, 1'b1);
        state_d    = ROW_B;
      end
      ROW_B: begin
        y0_d    = row_border_data_rd[10:0];
        state_d = ROW_W;
      end
      ROW_W: begin
        {y0_d, y1_d} = sanitize(y0_q, row_border_data_rd[10:0], Y_MAX);
        col_addr_d   = edge_addr(c_q, 1'b0);
        state_d      = COL_A;
      end
      COL_A: begin
        col_addr_d = edge_addr(c_q, 1'b1);
        state_d    = COL_B;
      end
      COL_B: begin
        x0_d    = col_border_data_rd[10:0];
        state_d = COL_W;
      end
      COL_W: begin
        {x0_d, x1_d} = sanitize(x0_q, col_border_data_rd[10:0], X_MAX);
        box_valid_d  = 1'b1;
        box_last_d   = (r_q + 4'd1 == nr_q) && (c_q + 4'd1 == nc_q);
        state_d      = EMIT;
      end
      EMIT: begin
        if (box_ready) begin
          box_valid_d = 1'b0;
          box_last_d  = 1'b0;
          box_idx_d   = box_idx_q + 8'd1;
          if (c_q + 4'd1 < nc_q) begin
            // Same row: row bounds are kept, only the column pair is re-read.
            c_d        = c_q + 4'd1;
            col_addr_d = edge_addr(c_q + 4'd1, 1'b0);
            state_d    = COL_A;
          end else if (r_q + 4'd1 < nr_q) begin
            r_d        = r_q + 4'd1;
            c_d        = 4'd0;
            row_addr_d = edge_addr(r_q + 4'd1, 1'b0);
            state_d    = ROW_A;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prev_flag_q <= 1'b0;
      nr_q        <= '0;
      nc_q        <= '0;
      r_q         <= '0;
      c_q         <= '0;
      row_addr_q  <= '0;
      col_addr_q  <= '0;
      x0_q        <= '0;
      x1_q        <= '0;
      y0_q        <= '0;
      y1_q        <= '0;
      box_valid_q <= 1'b0;
      box_last_q  <= 1'b0;
      box_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_flag_q <= project_done_flag;
      nr_q        <= nr_d;
      nc_q        <= nc_d;
      r_q         <= r_d;
      c_q         <= c_d;
      row_addr_q  <= row_addr_d;
      col_addr_q  <= col_addr_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      y0_q        <= y0_d;
      y1_q        <= y1_d;
      box_valid_q <= box_valid_d;
      box_last_q  <= box_last_d;
      box_idx_q   <= box_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign row_border_addr_rd = row_addr_q;
  assign col_border_addr_rd = col_addr_q;
  assign box_valid          = box_valid_q;
  assign box_x0             = x0_q;
  assign box_x1             = x1_q;
  assign box_y0             = y0_q;
  assign box_y1             = y1_q;
  assign box_idx            = box_idx_q;
  assign box_last           = box_last_q;
  assign scan_busy          = busy_q;
  assign scan_done          = done_q;

endmodule
`default_nettype wire

// File: tb/tb_border_box_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_border_box_scan
// Purpose  : Table-driven bench for border_box_scan with a 1-cycle border RAM
//            model, plus stall, zero-count, clamp and mid-scan reset cases.
// Revision : 1.0  initial release
// ============================================================================
module tb_border_box_scan;

  localparam int DEPBIT = 13;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              project_done_flag;
  logic [3:0]        num_row, num_col;
  logic [DEPBIT-1:0] row_border_addr_rd, row_border_data_rd;
  logic [DEPBIT-1:0] col_border_addr_rd, col_border_data_rd;
  logic              box_valid, box_ready;
  logic [10:0]       box_x0, box_x1, box_y0, box_y1;
  logic [7:0]        box_idx;
  logic              box_last, scan_busy, scan_done;

  border_box_scan #(
    .NUM_ROW(1), .NUM_COL(3), .H_PIXEL(1280), .V_PIXEL(720), .DEPBIT(DEPBIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .project_done_flag(project_done_flag),
    .num_row(num_row), .num_col(num_col),
    .row_border_addr_rd(row_border_addr_rd), .row_border_data_rd(row_border_data_rd),
    .col_border_addr_rd(col_border_addr_rd), .col_border_data_rd(col_border_data_rd),
    .box_valid(box_valid), .box_ready(box_ready),
    .box_x0(box_x0), .box_x1(box_x1), .box_y0(box_y0), .box_y1(box_y1),
    .box_idx(box_idx), .box_last(box_last), .scan_busy(scan_busy), .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  logic [DEPBIT-1:0] row_mem [16];
  logic [DEPBIT-1:0] col_mem [16];
  logic [DEPBIT-1:0] max_col;
  logic              clr_max;

  always @(posedge clk) begin
    row_border_data_rd <= row_mem[row_border_addr_rd[3:0]];
    col_border_data_rd <= col_mem[col_border_addr_rd[3:0]];
    if (clr_max) max_col <= '0;
    else if (col_border_addr_rd > max_col) max_col <= col_border_addr_rd;
  end

  typedef struct {
    logic [3:0]        nrow, ncol;
    logic [12:0]       rs, re;
    logic [2:0][12:0]  cs, ce;
    int                nbox;
    logic [2:0][10:0]  ex0, ex1;
    logic [10:0]       ey0, ey1;
    int                stall_box;
    int                done_cyc;
  } vec_t;

  vec_t vecs[7];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] all_outputs();
    return {row_border_addr_rd, col_border_addr_rd, box_valid, box_x0, box_x1,
            box_y0, box_y1, box_idx, box_last, scan_busy, scan_done};
  endfunction

  task automatic set_vec(input int i, input logic [3:0] nr, input logic [3:0] nc,
                         input logic [12:0] rs, input logic [12:0] re,
                         input logic [12:0] cs0, input logic [12:0] ce0,
                         input logic [12:0] cs1, input logic [12:0] ce1,
                         input logic [12:0] cs2, input logic [12:0] ce2,
                         input int nbox,
                         input logic [10:0] a0, input logic [10:0] b0,
                         input logic [10:0] a1, input logic [10:0] b1,
                         input logic [10:0] a2, input logic [10:0] b2,
                         input logic [10:0] ey0, input logic [10:0] ey1,
                         input int stall_box, input int done_cyc);
    vecs[i].nrow = nr;   vecs[i].ncol = nc;
    vecs[i].rs = rs;     vecs[i].re = re;
    vecs[i].cs[0] = cs0; vecs[i].ce[0] = ce0;
    vecs[i].cs[1] = cs1; vecs[i].ce[1] = ce1;
    vecs[i].cs[2] = cs2; vecs[i].ce[2] = ce2;
    vecs[i].nbox = nbox;
    vecs[i].ex0[0] = a0; vecs[i].ex1[0] = b0;
    vecs[i].ex0[1] = a1; vecs[i].ex1[1] = b1;
    vecs[i].ex0[2] = a2; vecs[i].ex1[2] = b2;
    vecs[i].ey0 = ey0;   vecs[i].ey1 = ey1;
    vecs[i].stall_box = stall_box;
    vecs[i].done_cyc  = done_cyc;
  endtask

  task automatic load_mem(input int vi);
    for (int k = 0; k < 16; k++) begin
      row_mem[k] = '0;
      col_mem[k] = '0;
    end
    row_mem[1] = vecs[vi].rs;
    row_mem[2] = vecs[vi].re;
    for (int c = 0; c < 3; c++) begin
      col_mem[2*c+1] = vecs[vi].cs[c];
      col_mem[2*c+2] = vecs[vi].ce[c];
    end
  endtask

  // One full scan: raise the flag, toggle it mid-scan, collect boxes, check timing.
  task automatic run_vec(input int vi);
    int          cyc, nb, done_at, stall_cnt;
    logic [52:0] snap, exp_box;
    logic        bad_idle;
    load_mem(vi);
    num_row = vecs[vi].nrow;
    num_col = vecs[vi].ncol;
    clr_max = 1'b1;
    @(negedge clk);
    clr_max = 1'b0;
    project_done_flag = 1'b1;
    box_ready = 1'b1;
    cyc = 0; nb = 0; done_at = -1; stall_cnt = 0; snap = '0;
    while (cyc < 100 && done_at < 0) begin
      @(negedge clk);
      cyc++;
      if (cyc == 3) project_done_flag = 1'b0;
      if (vecs[vi].nbox > 0 && cyc == 5) project_done_flag = 1'b1;
      if (cyc == 7) project_done_flag = 1'b0;
      if (cyc == 1) check($sformatf("v%0d busy_start", vi), scan_busy, 1);
      if (scan_done) begin
        done_at = cyc;
        check($sformatf("v%0d busy_at_done", vi), scan_busy, 0);
      end
      if (box_valid) begin
        if (vecs[vi].stall_box == nb && stall_cnt < 5) begin
          if (stall_cnt == 0)
            snap = {box_x0, box_x1, box_y0, box_y1, box_idx, box_last};
          else
            check($sformatf("v%0d stall_hold%0d", vi, stall_cnt),
                  {box_valid, box_x0, box_x1, box_y0, box_y1, box_idx, box_last}, {1'b1, snap});
          stall_cnt++;
          box_ready = 1'b0;
        end else begin
          box_ready = 1'b1;
          if (nb >= vecs[vi].nbox || nb > 2) begin
            check($sformatf("v%0d extra_box", vi), nb, vecs[vi].nbox - 1);
          end else begin
            exp_box = {vecs[vi].ex0[nb], vecs[vi].ex1[nb], vecs[vi].ey0, vecs[vi].ey1,
                       8'(nb), (nb == vecs[vi].nbox - 1)};
            check($sformatf("v%0d box%0d x0x1y0y1idxlast", vi, nb),
                  {box_x0, box_x1, box_y0, box_y1, box_idx, box_last}, exp_box);
          end
          nb++;
        end
      end else begin
        box_ready = 1'b1;
      end
    end
    project_done_flag = 1'b0;
    box_ready = 1'b1;
    check($sformatf("v%0d done_cycle", vi), done_at, vecs[vi].done_cyc);
    check($sformatf("v%0d box_count", vi), nb, vecs[vi].nbox);
    check($sformatf("v%0d col_addr_le6", vi), max_col <= 13'd6, 1);
    bad_idle = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bad_idle = bad_idle | scan_done | box_valid | scan_busy;
    end
    check($sformatf("v%0d post_idle", vi), bad_idle, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    project_done_flag = 1'b0;
    num_row = '0;
    num_col = '0;
    box_ready = 1'b1;
    clr_max = 1'b1;
    for (int k = 0; k < 16; k++) begin
      row_mem[k] = '0;
      col_mem[k] = '0;
    end

    //      nr  nc  rs    re    cs0       ce0   cs1   ce1   cs2   ce2  nbox  x0/x1 per box             y0   y1   stall done
    set_vec(0, 1, 3, 198,  502,  98,       202,  298,  402,  498,  602,  3,  98,202, 298,402, 498,602,  198, 502, -1, 17);
    set_vec(1, 1, 3, 198,  502,  98,       202,  298,  402,  498,  602,  3,  98,202, 298,402, 498,602,  198, 502,  1, 22);
    set_vec(2, 1, 0, 198,  502,  98,       202,  298,  402,  498,  602,  0,  0,0,    0,0,     0,0,      0,   0,  -1,  2);
    set_vec(3, 3, 9, 198,  502,  4096+98,  202,  298,  402,  498,  602,  3,  98,202, 298,402, 498,602,  198, 502, -1, 17);
    set_vec(4, 1, 2, 2046, 5,    2046,     5,    100,  1300, 0,    0,    2,  0,5,    100,1279, 0,0,     0,   5,  -1, 13);
    set_vec(5, 1, 1, 700,  800,  1290,     1300, 0,    0,    0,    0,    1,  1279,1279, 0,0,   0,0,      700, 719, -1,  9);
    set_vec(6, 0, 3, 198,  502,  98,       202,  298,  402,  498,  602,  0,  0,0,    0,0,     0,0,      0,   0,  -1,  2);

    repeat (3) @(negedge clk);
    check("reset_outputs", all_outputs(), '0);
    rst_n = 1'b1;
    clr_max = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 7; v++) run_vec(v);

    // Reset while COL_W of the first box: six cycles after the flag rise.
    load_mem(0);
    num_row = 4'd1;
    num_col = 4'd3;
    project_done_flag = 1'b1;
    begin
      logic early_valid;
      early_valid = 1'b0;
      repeat (6) begin
        @(negedge clk);
        early_valid = early_valid | box_valid;
      end
      check("pre_rst_no_valid", early_valid, 0);
    end
    rst_n = 1'b0;
    project_done_flag = 1'b0;
    #1;
    check("async_rst_outputs", all_outputs(), '0);
    @(negedge clk);
    check("rst_held_outputs", all_outputs(), '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_vec(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
